// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: FSM encoding,
// default widths and a constant-evaluable clog2 helper.
package wb_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUS     = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_t;

   localparam int DEFAULT_NUM_MASTERS    = 4;
   localparam int DEFAULT_DATA_WIDTH     = 32;
   localparam int DEFAULT_ADDR_WIDTH     = 8;
   localparam int DEFAULT_TIMEOUT_CYCLES = 255;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin winner selection: rotate the request vector so the
// search begins after the previous winner, find the first set bit, unrotate.
module rr_priority_picker
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
   parameter int IDX_W       = clog2(DEFAULT_NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] i_req,
   input  logic [IDX_W-1:0]       i_lastGrant,
   output logic                   o_valid,
   output logic [NUM_MASTERS-1:0] o_grant,
   output logic [IDX_W-1:0]       o_index
);

   logic [NUM_MASTERS-1:0] w_rotated;
   int                     w_start;
   int                     w_offset;
   int                     w_winner;

   always_comb begin
      w_start = (int'(i_lastGrant) >= NUM_MASTERS - 1) ? 0 : int'(i_lastGrant) + 1;
   end

   always_comb begin
      w_rotated = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         w_rotated[i] = i_req[IDX_W'((w_start + i) % NUM_MASTERS)];
      end
   end

   // Scanning downward lets the lowest rotated position win.
   always_comb begin
      w_offset = 0;
      o_valid  = 1'b0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (w_rotated[i]) begin
            w_offset = i;
            o_valid  = 1'b1;
         end
      end
   end

   assign w_winner = (w_start + w_offset) % NUM_MASTERS;
   assign o_index  = IDX_W'(w_winner);

   always_comb begin
      o_grant = '0;
      if (o_valid) o_grant[o_index] = 1'b1;
   end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave bus between several masters,
// turning the slave's held ack into one-cycle pulses and timing out dead slaves.
module wb_rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = DEFAULT_NUM_MASTERS,
   parameter int BUS_DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int BUS_ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                                       wb_clk_i,
   input  logic                                       wb_rst_i,
   input  logic [NUM_MASTERS-1:0]                     wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]                     wbm_stb_i,
   input  logic [NUM_MASTERS-1:0]                     wbm_we_i,
   input  logic [NUM_MASTERS*(BUS_DATA_WIDTH/8)-1:0]  wbm_sel_i,
   input  logic [NUM_MASTERS*BUS_ADDR_WIDTH-1:0]      wbm_adr_i,
   input  logic [NUM_MASTERS*BUS_DATA_WIDTH-1:0]      wbm_dat_i,
   output logic [BUS_DATA_WIDTH-1:0]                  wbm_dat_o,
   output logic [NUM_MASTERS-1:0]                     wbm_ack_o,
   output logic [NUM_MASTERS-1:0]                     wbm_err_o,
   output logic                                       wbs_cyc_o,
   output logic                                       wbs_stb_o,
   output logic                                       wbs_we_o,
   output logic [(BUS_DATA_WIDTH/8)-1:0]              wbs_sel_o,
   output logic [BUS_ADDR_WIDTH-1:0]                  wbs_adr_o,
   output logic [BUS_DATA_WIDTH-1:0]                  wbs_dat_o,
   input  logic [BUS_DATA_WIDTH-1:0]                  wbs_dat_i,
   input  logic                                       wbs_ack_i,
   input  logic                                       wbs_err_i,
   output logic [NUM_MASTERS-1:0]                     grant_o
);

   localparam int BYTE_ENABLES = BUS_DATA_WIDTH / 8;
   localparam int IDX_W        = clog2(NUM_MASTERS);
   localparam int CNT_W        = clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_t             r_state;
   arb_state_t             w_nextState;
   logic [IDX_W-1:0]       r_lastGrant;
   logic [IDX_W-1:0]       r_owner;
   logic [CNT_W-1:0]       r_count;
   logic [NUM_MASTERS-1:0] w_req;
   logic                   w_pickValid;
   logic [NUM_MASTERS-1:0] w_pickGrant;
   logic [IDX_W-1:0]       w_pickIndex;
   logic                   w_timeout;
   logic                   w_exitBus;
   logic                   w_exitAck;
   logic                   w_exitErr;

   assign w_req     = wbm_cyc_i & wbm_stb_i;
   assign w_timeout = (r_count == CNT_LAST);

   rr_priority_picker #(
      .NUM_MASTERS (NUM_MASTERS),
      .IDX_W       (IDX_W)
   ) u_picker (
      .i_req       (w_req),
      .i_lastGrant (r_lastGrant),
      .o_valid     (w_pickValid),
      .o_grant     (w_pickGrant),
      .o_index     (w_pickIndex)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) r_state <= ST_IDLE;
      else          r_state <= w_nextState;
   end

   // Error beats ack when both arrive; a timeout only counts without either.
   always_comb begin
      w_nextState = r_state;
      w_exitBus   = 1'b0;
      w_exitAck   = 1'b0;
      w_exitErr   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_pickValid) w_nextState = ST_BUS;
         end
         ST_BUS: begin
            w_exitErr = wbs_err_i | (w_timeout & ~wbs_ack_i);
            w_exitAck = wbs_ack_i & ~wbs_err_i;
            w_exitBus = wbs_ack_i | wbs_err_i | w_timeout | ~wbm_cyc_i[r_owner];
            if (w_exitBus) w_nextState = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (!wbs_ack_i && !wbs_err_i) w_nextState = ST_IDLE;
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_lastGrant <= IDX_W'(NUM_MASTERS - 1);
         r_owner     <= '0;
         r_count     <= '0;
         grant_o     <= '0;
         wbm_dat_o   <= '0;
         wbm_ack_o   <= '0;
         wbm_err_o   <= '0;
         wbs_cyc_o   <= 1'b0;
         wbs_stb_o   <= 1'b0;
         wbs_we_o    <= 1'b0;
         wbs_sel_o   <= '0;
         wbs_adr_o   <= '0;
         wbs_dat_o   <= '0;
      end else begin
         wbm_ack_o <= '0;
         wbm_err_o <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_pickValid) begin
                  grant_o     <= w_pickGrant;
                  r_owner     <= w_pickIndex;
                  r_lastGrant <= w_pickIndex;
                  r_count     <= '0;
                  wbs_cyc_o   <= 1'b1;
                  wbs_stb_o   <= 1'b1;
                  wbs_we_o    <= wbm_we_i[w_pickIndex];
                  wbs_sel_o   <= wbm_sel_i[int'(w_pickIndex)*BYTE_ENABLES +: BYTE_ENABLES];
                  wbs_adr_o   <= wbm_adr_i[int'(w_pickIndex)*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH];
                  wbs_dat_o   <= wbm_dat_i[int'(w_pickIndex)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
               end
            end
            ST_BUS: begin
               if (w_exitBus) begin
                  wbs_cyc_o <= 1'b0;
                  wbs_stb_o <= 1'b0;
                  grant_o   <= '0;
                  if (w_exitAck) begin
                     wbm_ack_o[r_owner] <= 1'b1;
                     wbm_dat_o          <= wbs_dat_i;
                  end
                  if (w_exitErr) wbm_err_o[r_owner] <= 1'b1;
               end else if (r_count != '1) begin
                  r_count <= r_count + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter with a hold-ack slave model
// whose ack/err responses can be enabled independently.
module tb_wb_rr_arbiter;

   localparam int NM = 4;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int BE = DW / 8;
   localparam int TO = 8;

   logic             clock = 1'b0;
   logic             reset;
   logic [NM-1:0]    mCyc, mStb, mWe;
   logic [NM*BE-1:0] mSel;
   logic [NM*AW-1:0] mAdr;
   logic [NM*DW-1:0] mDat;
   logic [DW-1:0]    datOut;
   logic [NM-1:0]    ackOut, errOut, grant;
   logic             sCyc, sStb, sWe;
   logic [BE-1:0]    sSel;
   logic [AW-1:0]    sAdr;
   logic [DW-1:0]    sDatO, sDatI;
   logic             sAck = 1'b0;
   logic             sErr = 1'b0;
   logic             slaveAckEn, slaveErrEn;
   logic [DW-1:0]    slaveRdata;
   int               compared   = 0;
   int               mismatched = 0;

   wb_rr_arbiter #(
      .NUM_MASTERS    (NM),
      .BUS_DATA_WIDTH (DW),
      .BUS_ADDR_WIDTH (AW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .wb_clk_i  (clock),
      .wb_rst_i  (reset),
      .wbm_cyc_i (mCyc),
      .wbm_stb_i (mStb),
      .wbm_we_i  (mWe),
      .wbm_sel_i (mSel),
      .wbm_adr_i (mAdr),
      .wbm_dat_i (mDat),
      .wbm_dat_o (datOut),
      .wbm_ack_o (ackOut),
      .wbm_err_o (errOut),
      .wbs_cyc_o (sCyc),
      .wbs_stb_o (sStb),
      .wbs_we_o  (sWe),
      .wbs_sel_o (sSel),
      .wbs_adr_o (sAdr),
      .wbs_dat_o (sDatO),
      .wbs_dat_i (sDatI),
      .wbs_ack_i (sAck),
      .wbs_err_i (sErr),
      .grant_o   (grant)
   );

   always #5 clock = ~clock;

   // Registered slave: responds one cycle after seeing stb and holds until stb drops.
   assign sDatI = slaveRdata;
   always @(posedge clock) begin
      sAck <= slaveAckEn & sCyc & sStb;
      sErr <= slaveErrEn & sCyc & sStb;
   end

   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int m, input logic we, input logic [AW-1:0] adr,
                                input logic [DW-1:0] dat, input logic [BE-1:0] sel);
      mCyc[m]           = 1'b1;
      mStb[m]           = 1'b1;
      mWe[m]            = we;
      mSel[m*BE +: BE]  = sel;
      mAdr[m*AW +: AW]  = adr;
      mDat[m*DW +: DW]  = dat;
   endtask

   task automatic dropMaster(input int m);
      mCyc[m] = 1'b0;
      mStb[m] = 1'b0;
   endtask

   task automatic waitForGrant(input string tag, input int limit, output int used);
      used = 0;
      while (grant == '0 && used < limit) begin
         stepCycle();
         used++;
      end
      checkOutput(tag, {63'd0, grant != '0}, 64'd1);
   endtask

   task automatic waitForDrop(input string tag, input int limit, output int used);
      used = 0;
      while (grant != '0 && used < limit) begin
         stepCycle();
         used++;
      end
      checkOutput(tag, {63'd0, grant == '0}, 64'd1);
   endtask

   task automatic waitForPulse(input string tag, input int limit);
      int used;
      used = 0;
      while ((ackOut | errOut) == '0 && used < limit) begin
         stepCycle();
         used++;
      end
      checkOutput(tag, {63'd0, (ackOut | errOut) != '0}, 64'd1);
   endtask

   initial begin
      int used, dropUsed, riseUsed, stray;
      int order [5];
      order = '{0, 1, 2, 3, 0};

      reset = 1'b1;
      mCyc = '0; mStb = '0; mWe = '0; mSel = '0; mAdr = '0; mDat = '0;
      slaveAckEn = 1'b1; slaveErrEn = 1'b0; slaveRdata = '0;
      repeat (2) stepCycle();
      checkOutput("resetGrant", grant, 0);
      checkOutput("resetStb", sStb, 0);
      checkOutput("resetAck", ackOut, 0);
      checkOutput("resetDat", datOut, 0);
      reset = 1'b0;
      stepCycle();

      $display("[TB] single write from master 2");
      applyStimulus(2, 1'b1, 8'h00, 32'hDEADBEEF, 4'hF);
      stepCycle();
      checkOutput("t1Grant", grant, 4'b0100);
      checkOutput("t1Cyc", sCyc, 1);
      checkOutput("t1Stb", sStb, 1);
      checkOutput("t1We", sWe, 1);
      checkOutput("t1Adr", sAdr, 8'h00);
      checkOutput("t1Dat", sDatO, 32'hDEADBEEF);
      checkOutput("t1Sel", sSel, 4'hF);
      stepCycle();
      checkOutput("t1NoEarlyAck", ackOut, 0);
      stepCycle();
      checkOutput("t1Ack", ackOut, 4'b0100);
      checkOutput("t1StbLow", sStb, 0);
      checkOutput("t1GrantIdle", grant, 0);
      dropMaster(2);
      stepCycle();
      checkOutput("t1AckSingle", ackOut, 0);
      repeat (2) stepCycle();

      $display("[TB] all masters requesting continuously");
      #2 reset = 1'b1;
      #1 reset = 1'b0;
      for (int m = 0; m < NM; m++) applyStimulus(m, 1'b1, AW'(m), DW'(32'h100 + m), 4'hF);
      waitForGrant("t2FirstGrantSeen", 10, used);
      checkOutput("t2Grant0", grant, 64'(1 << order[0]));
      for (int k = 1; k < 5; k++) begin
         waitForDrop("t2DropSeen", 10, dropUsed);
         waitForGrant("t2GrantSeen", 10, riseUsed);
         checkOutput($sformatf("t2Grant%0d", k), grant, 64'(1 << order[k]));
         checkOutput($sformatf("t2Spacing%0d", k), 64'(dropUsed + riseUsed), 64'd5);
      end
      for (int m = 0; m < NM; m++) dropMaster(m);
      repeat (6) stepCycle();

      $display("[TB] read from master 1");
      slaveRdata = 32'h12345678;
      applyStimulus(1, 1'b0, 8'h10, 32'h0, 4'hF);
      stepCycle();
      checkOutput("t3Grant", grant, 4'b0010);
      checkOutput("t3We", sWe, 0);
      checkOutput("t3Adr", sAdr, 8'h10);
      waitForPulse("t3PulseSeen", 10);
      checkOutput("t3Ack", ackOut, 4'b0010);
      checkOutput("t3Data", datOut, 32'h12345678);
      dropMaster(1);
      repeat (4) stepCycle();

      $display("[TB] timeout with silent slave");
      slaveAckEn = 1'b0;
      applyStimulus(3, 1'b1, 8'h20, 32'h0BADF00D, 4'h3);
      stepCycle();
      checkOutput("t4Grant", grant, 4'b1000);
      stray = 0;
      for (int j = 1; j < TO; j++) begin
         stepCycle();
         if ((ackOut | errOut) != '0) stray++;
      end
      checkOutput("t4NoEarlyPulse", 64'(stray), 0);
      stepCycle();
      checkOutput("t4Err", errOut, 4'b1000);
      checkOutput("t4NoAck", ackOut, 0);
      checkOutput("t4StbLow", sStb, 0);
      dropMaster(3);
      stepCycle();
      checkOutput("t4ErrSingle", errOut, 0);
      repeat (3) stepCycle();

      $display("[TB] owner abort");
      applyStimulus(0, 1'b0, 8'h30, 32'h0, 4'h1);
      stepCycle();
      checkOutput("t5aGrant", grant, 4'b0001);
      repeat (2) stepCycle();
      dropMaster(0);
      stepCycle();
      checkOutput("t5aStbLow", sStb, 0);
      checkOutput("t5aGrantIdle", grant, 0);
      stray = 0;
      for (int j = 0; j < 4; j++) begin
         if ((ackOut | errOut) != '0) stray++;
         stepCycle();
      end
      checkOutput("t5aNoPulse", 64'(stray), 0);

      $display("[TB] simultaneous ack and err");
      slaveAckEn = 1'b1;
      slaveErrEn = 1'b1;
      slaveRdata = 32'hCAFEF00D;
      applyStimulus(2, 1'b0, 8'h40, 32'h0, 4'hF);
      waitForGrant("t5bGrantSeen", 10, used);
      checkOutput("t5bGrant", grant, 4'b0100);
      waitForPulse("t5bPulseSeen", 10);
      checkOutput("t5bErr", errOut, 4'b0100);
      checkOutput("t5bNoAck", ackOut, 0);
      checkOutput("t5bDataKept", datOut, 32'h12345678);
      dropMaster(2);
      repeat (4) stepCycle();

      $display("[TB] asynchronous reset mid-transfer");
      slaveAckEn = 1'b0;
      slaveErrEn = 1'b0;
      applyStimulus(1, 1'b1, 8'h50, 32'h55AA55AA, 4'hF);
      stepCycle();
      checkOutput("t6Grant", grant, 4'b0010);
      stepCycle();
      #3 reset = 1'b1;
      #1;
      checkOutput("t6RstGrant", grant, 0);
      checkOutput("t6RstCyc", sCyc, 0);
      checkOutput("t6RstStb", sStb, 0);
      checkOutput("t6RstDatOut", datOut, 0);
      checkOutput("t6RstSlaveDat", sDatO, 0);
      stepCycle();
      reset = 1'b0;
      dropMaster(1);
      slaveAckEn = 1'b1;
      applyStimulus(2, 1'b1, 8'h60, 32'h1, 4'hF);
      applyStimulus(0, 1'b1, 8'h70, 32'h2, 4'hF);
      stepCycle();
      checkOutput("t6MasterZeroFirst", grant, 4'b0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
